// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration sequencer.
// Holds DRP register map, FSM states and the divide encoder.
package mmcm_drp_pkg;

   localparam int unsigned CNT_W = 16;

   localparam logic [6:0]  ADDR_REG1 = 7'h08;
   localparam logic [6:0]  ADDR_REG2 = 7'h09;
   localparam logic [15:0] KEEP_REG1 = 16'h1000;
   localparam logic [15:0] KEEP_REG2 = 16'hFF00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_RD,
      S_WAIT_RD,
      S_WR,
      S_WAIT_WR,
      S_REL,
      S_WAIT_LOCK
   } state_t;

   // Returns {ClkReg1 new bits, ClkReg2 new bits}; kept fields are zero.
   function automatic logic [31:0] div_enc(input logic [6:0] div);
      logic [5:0] hi;
      logic [5:0] lo;
      logic [6:0] diff;
      logic       edg;
      logic       nocnt;
      diff = div - {1'b0, div[6:1]};
      if (div == 7'd1) begin
         hi    = 6'd1;
         lo    = 6'd1;
         edg   = 1'b0;
         nocnt = 1'b1;
      end else begin
         hi    = div[6:1];
         lo    = diff[5:0];
         edg   = div[0];
         nocnt = 1'b0;
      end
      return {4'b0000, hi, lo, 8'h00, edg, nocnt, 6'd0};
   endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Resets to 0 so a stale input never appears asserted after reset.
module sync2 (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] r_sync;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], d_i};
      end
   end

   assign q_o = r_sync[1];

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Retunes MMCM CLKOUT0 via DRP: reset, read-modify-write two words,
// release reset and wait for lock. Runs on the board clock only.
module mmcm_drp_ctrl
   import mmcm_drp_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned DRP_TIMEOUT  = 255
) (
   input  logic        clk100_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   input  logic [6:0]  div_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        mmcm_rst_o,
   input  logic        locked_i,
   output logic        drp_den_o,
   output logic        drp_dwe_o,
   output logic [6:0]  drp_daddr_o,
   output logic [15:0] drp_di_o,
   input  logic [15:0] drp_do_i,
   input  logic        drp_drdy_i
);

   // Counter is loaded so the bound expires T cycles after the den/REL cycle.
   localparam logic [CNT_W-1:0] DRP_LOAD  = CNT_W'(DRP_TIMEOUT - 2);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 2);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_idx;
   logic              w_idx_nxt;
   logic [6:0]        r_div;
   logic [6:0]        w_div_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_busy;
   logic              r_done;
   logic              w_done_nxt;
   logic              r_err;
   logic              w_err_nxt;
   logic              r_mmcm_rst;
   logic              r_den;
   logic              r_dwe;
   logic [6:0]        r_daddr;
   logic [6:0]        w_daddr_nxt;
   logic [15:0]       r_di;
   logic [15:0]       w_di_nxt;
   logic              w_locked;
   logic [31:0]       w_enc;
   logic [15:0]       w_new;
   logic [15:0]       w_keep;

   sync2 u_lock_sync (
      .clk_i   (clk100_i),
      .rst_n_i (rst_n_i),
      .d_i     (locked_i),
      .q_o     (w_locked)
   );

   assign w_enc  = div_enc(r_div);
   assign w_new  = r_idx ? w_enc[15:0] : w_enc[31:16];
   assign w_keep = r_idx ? KEEP_REG2 : KEEP_REG1;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_div_nxt   = r_div;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_daddr_nxt = r_daddr;
      w_di_nxt    = r_di;
      unique case (r_state)
         S_IDLE: begin
            if (req_i) begin
               if (div_i == 7'd0 || div_i == 7'd127) begin
                  w_err_nxt  = 1'b1;
                  w_done_nxt = 1'b1;
               end else begin
                  w_div_nxt   = div_i;
                  w_err_nxt   = 1'b0;
                  w_state_nxt = S_RST;
               end
            end
         end
         S_RST: begin
            w_idx_nxt   = 1'b0;
            w_daddr_nxt = ADDR_REG1;
            w_state_nxt = S_RD;
         end
         S_RD: begin
            w_cnt_nxt   = DRP_LOAD;
            w_state_nxt = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (drp_drdy_i) begin
               w_di_nxt    = (drp_do_i & w_keep) | w_new;
               w_state_nxt = S_WR;
            end else if (r_cnt == '0) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_REL;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_WR: begin
            w_cnt_nxt   = DRP_LOAD;
            w_state_nxt = S_WAIT_WR;
         end
         S_WAIT_WR: begin
            if (drp_drdy_i) begin
               if (!r_idx) begin
                  w_idx_nxt   = 1'b1;
                  w_daddr_nxt = ADDR_REG2;
                  w_state_nxt = S_RD;
               end else begin
                  w_state_nxt = S_REL;
               end
            end else if (r_cnt == '0) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_REL;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_REL: begin
            w_cnt_nxt   = LOCK_LOAD;
            w_state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (w_locked) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_err_nxt   = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they align with it.
   always_ff @(posedge clk100_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_idx      <= 1'b0;
         r_div      <= 7'd0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_mmcm_rst <= 1'b0;
         r_den      <= 1'b0;
         r_dwe      <= 1'b0;
         r_daddr    <= 7'd0;
         r_di       <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_div      <= w_div_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_mmcm_rst <= (w_state_nxt inside
                        {S_RST, S_RD, S_WAIT_RD, S_WR, S_WAIT_WR});
         r_den      <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
         r_dwe      <= (w_state_nxt == S_WR);
         r_daddr    <= w_daddr_nxt;
         r_di       <= w_di_nxt;
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign mmcm_rst_o  = r_mmcm_rst;
   assign drp_den_o   = r_den;
   assign drp_dwe_o   = r_dwe;
   assign drp_daddr_o = r_daddr;
   assign drp_di_o    = r_di;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl with short timeouts.
// Inputs driven and outputs sampled 1 ns after each rising edge.
module tb_mmcm_drp_ctrl;

   localparam int unsigned LT = 40;
   localparam int unsigned DT = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [6:0]  div;
   logic        busy;
   logic        done;
   logic        err;
   logic        mrst;
   logic        locked;
   logic        den;
   logic        dwe;
   logic [6:0]  daddr;
   logic [15:0] di;
   logic [15:0] dout;
   logic        drdy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mmcm_drp_ctrl #(
      .LOCK_TIMEOUT (LT),
      .DRP_TIMEOUT  (DT)
   ) dut (
      .clk100_i    (clk),
      .rst_n_i     (rst_n),
      .req_i       (req),
      .div_i       (div),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .mmcm_rst_o  (mrst),
      .locked_i    (locked),
      .drp_den_o   (den),
      .drp_dwe_o   (dwe),
      .drp_daddr_o (daddr),
      .drp_di_o    (di),
      .drp_do_i    (dout),
      .drp_drdy_i  (drdy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " err"}, 32'(err), 0);
      chk({tag, " mrst"}, 32'(mrst), 0);
      chk({tag, " den"}, 32'(den), 0);
      chk({tag, " dwe"}, 32'(dwe), 0);
      chk({tag, " daddr"}, 32'(daddr), 0);
      chk({tag, " di"}, 32'(di), 0);
   endtask

   // Full request with drdy one cycle after each den; lk=0 withholds lock.
   task automatic run_seq(input logic [6:0] dv, input logic [15:0] r0,
                          input logic [15:0] r1, input logic [15:0] w0,
                          input logic [15:0] w1, input logic lk);
      req = 1'b1;
      div = dv;
      tick();
      req = 1'b0;
      locked = 1'b0;
      chk("acc busy", 32'(busy), 1);
      chk("acc mrst", 32'(mrst), 1);
      chk("acc err", 32'(err), 0);
      chk("acc den", 32'(den), 0);
      for (int w = 0; w < 2; w++) begin
         tick();
         chk("rd den", 32'(den), 1);
         chk("rd dwe", 32'(dwe), 0);
         chk("rd addr", 32'(daddr), w ? 'h09 : 'h08);
         tick();
         chk("wrd den", 32'(den), 0);
         drdy = 1'b1;
         dout = w ? r1 : r0;
         tick();
         drdy = 1'b0;
         dout = 16'h0;
         chk("wr den", 32'(den), 1);
         chk("wr dwe", 32'(dwe), 1);
         chk("wr addr", 32'(daddr), w ? 'h09 : 'h08);
         chk("wr di", 32'(di), w ? 32'(w1) : 32'(w0));
         tick();
         chk("wwr den", 32'(den), 0);
         chk("wwr mrst", 32'(mrst), 1);
         drdy = 1'b1;
      end
      tick();
      drdy = 1'b0;
      chk("rel mrst", 32'(mrst), 0);
      chk("rel busy", 32'(busy), 1);
      if (lk) begin
         tick();
         locked = 1'b1;
         tick();
         tick();
         chk("pre done", 32'(done), 0);
         tick();
         chk("done", 32'(done), 1);
         chk("done busy", 32'(busy), 0);
         chk("done err", 32'(err), 0);
         tick();
         chk("done pulse", 32'(done), 0);
      end else begin
         for (int i = 0; i < int'(LT) - 1; i++) tick();
         chk("lto pre done", 32'(done), 0);
         tick();
         chk("lto done", 32'(done), 1);
         chk("lto err", 32'(err), 1);
         chk("lto mrst", 32'(mrst), 0);
         chk("lto busy", 32'(busy), 0);
         tick();
      end
   endtask

   task automatic run_reject(input logic [6:0] dv);
      req = 1'b1;
      div = dv;
      tick();
      req = 1'b0;
      chk("rej err", 32'(err), 1);
      chk("rej done", 32'(done), 1);
      chk("rej busy", 32'(busy), 0);
      chk("rej mrst", 32'(mrst), 0);
      chk("rej den", 32'(den), 0);
      tick();
      chk("rej done pulse", 32'(done), 0);
      chk("rej err sticky", 32'(err), 1);
      chk("rej den2", 32'(den), 0);
      chk("rej mrst2", 32'(mrst), 0);
   endtask

   initial begin
      rst_n  = 1'b0;
      req    = 1'b0;
      div    = 7'd0;
      locked = 1'b0;
      dout   = 16'h0;
      drdy   = 1'b0;
      tick();
      tick();
      chk_idle_outs("reset");
      rst_n = 1'b1;
      tick();

      run_seq(7'd64, 16'h1FFF, 16'hABCD, 16'h1820, 16'hAB00, 1'b1);
      run_seq(7'd7, 16'h0000, 16'h0000, 16'h00C4, 16'h0080, 1'b1);
      run_seq(7'd1, 16'h0000, 16'h0000, 16'h0041, 16'h0040, 1'b1);
      run_reject(7'd0);
      run_reject(7'd127);
      run_seq(7'd126, 16'hFFFF, 16'hFFFF, 16'h1FFF, 16'hFF00, 1'b0);

      // DRP read never answered
      req = 1'b1;
      div = 7'd64;
      tick();
      req = 1'b0;
      locked = 1'b0;
      chk("dto acc err", 32'(err), 0);
      tick();
      chk("dto den", 32'(den), 1);
      for (int i = 0; i < int'(DT) - 1; i++) tick();
      chk("dto pre mrst", 32'(mrst), 1);
      chk("dto pre err", 32'(err), 0);
      chk("dto pre den", 32'(den), 0);
      tick();
      chk("dto mrst", 32'(mrst), 0);
      chk("dto err", 32'(err), 1);
      chk("dto busy", 32'(busy), 1);
      tick();
      locked = 1'b1;
      tick();
      tick();
      chk("dto pre done", 32'(done), 0);
      tick();
      chk("dto done", 32'(done), 1);
      chk("dto done err", 32'(err), 1);
      tick();

      // Reset pulse while waiting for read data
      req = 1'b1;
      div = 7'd64;
      tick();
      req = 1'b0;
      locked = 1'b0;
      tick();
      tick();
      chk("mid mrst", 32'(mrst), 1);
      chk("mid addr", 32'(daddr), 'h08);
      rst_n = 1'b0;
      #1;
      chk_idle_outs("mid reset");
      tick();
      rst_n = 1'b1;
      tick();
      run_seq(7'd64, 16'h1FFF, 16'hABCD, 16'h1820, 16'hAB00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
